sync_result_sink: RTL and testbench

//  Consumer end of the sync valid/ready stream emitted by compiled kernels (out_valid/out_ready/out0).

---
 rtl/sync_result_sink.sv | 158 +++++++++++++++
 tb/tb_sync_result_sink.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_result_sink.sv
// Consumer end of a kernel valid/ready result stream: stamps each accepted word with its
// issue-to-result latency, compares it against the job's expected value, and queues it in a FWFT FIFO.
//
// state  | meaning
// IDLE   | no job in flight; an accepted result here is recorded as spurious
// RUN    | one job issued; timer counts cycles since its start
module sync_result_sink #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int LATW    = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_expected,
  input  logic             i_check_en,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in0,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [LATW-1:0]  o_rd_lat,
  output logic             o_rd_err,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_busy,
  output logic [7:0]       o_err_count,
  output logic             o_timeout,
  output logic             o_spurious
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [LATW-1:0] TMO_C   = LATW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [LATW-1:0]  r_timer;
  logic [WIDTH-1:0] r_exp;
  logic             r_chk;
  logic [7:0]       r_err_count;
  logic             r_timeout;
  logic             r_spurious;

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [LATW-1:0]  r_mem_lat  [DEPTH];
  logic             r_mem_err  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic [LATW-1:0]  w_push_lat;
  logic             w_push_err;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH_C);
  assign w_accept = i_in_valid && !w_full;
  assign w_pop    = i_rd_en && !w_empty;

  // Results accepted outside a job carry lat=0 and are never flagged as mismatches.
  always_comb begin
    w_push     = 1'b0;
    w_push_lat = '0;
    w_push_err = 1'b0;
    if (w_accept) begin
      w_push = 1'b1;
      if (r_state == S_RUN) begin
        w_push_lat = r_timer;
        w_push_err = r_chk && (i_in0 != r_exp);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_exp       <= '0;
      r_chk       <= 1'b0;
      r_err_count <= '0;
      r_timeout   <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_spurious <= 1'b1;
          if (i_start) begin
            r_state <= S_RUN;
            r_timer <= LATW'(1);
            r_exp   <= i_expected;
            r_chk   <= i_check_en;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (i_start) begin
              r_timer <= LATW'(1);
              r_exp   <= i_expected;
              r_chk   <= i_check_en;
            end else begin
              r_state <= S_IDLE;
              r_timer <= '0;
            end
          end else if (r_timer == TMO_C) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
            r_timer   <= '0;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + LATW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_push && w_push_err && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  // Storage needs no reset: reads are masked to zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_in0;
      r_mem_lat[r_wr_ptr]  <= w_push_lat;
      r_mem_err[r_wr_ptr]  <= w_push_err;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  assign o_in_ready  = !w_full;
  assign o_rd_data   = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign o_rd_lat    = w_empty ? '0 : r_mem_lat[r_rd_ptr];
  assign o_rd_err    = w_empty ? 1'b0 : r_mem_err[r_rd_ptr];
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_busy      = (r_state == S_RUN);
  assign o_err_count = r_err_count;
  assign o_timeout   = r_timeout;
  assign o_spurious  = r_spurious;

endmodule

// File: tb/tb_sync_result_sink.sv
// Bench for sync_result_sink: directed scenarios plus random traffic, checked every cycle against
// a cycle-stamped job/record queue model.
module tb_sync_result_sink;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;
  localparam int LATW    = 10;
  localparam int TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] expv = '0;
  logic             chk_en = 1'b0;
  logic             vin = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in0 = '0;
  logic             rden = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic [LATW-1:0]  rd_lat;
  logic             rd_err;
  logic             empty, full, busy, timeout, spurious;
  logic [7:0]       err_count;

  sync_result_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATW(LATW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_expected(expv), .i_check_en(chk_en),
    .i_in_valid(vin), .o_in_ready(in_ready), .i_in0(in0), .i_rd_en(rden),
    .o_rd_data(rd_data), .o_rd_lat(rd_lat), .o_rd_err(rd_err), .o_empty(empty),
    .o_full(full), .o_busy(busy), .o_err_count(err_count), .o_timeout(timeout),
    .o_spurious(spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               lat;
    bit               e;
  } rec_t;

  rec_t             mq[$];
  bit               m_active;
  int               m_st;
  logic [WIDTH-1:0] m_exp;
  bit               m_chk;
  int               m_errs;
  bit               m_tmo;
  bit               m_spur;
  int               cyc = 0;
  bit               hold;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("busy", 32'(busy), 32'(m_active));
    chk("err_count", 32'(err_count), 32'(m_errs));
    chk("timeout", 32'(timeout), 32'(m_tmo));
    chk("spurious", 32'(spurious), 32'(m_spur));
    chk("rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0].d) : 32'd0);
    chk("rd_lat", 32'(rd_lat), (mq.size() > 0) ? 32'(mq[0].lat) : 32'd0);
    chk("rd_err", 32'(rd_err), (mq.size() > 0) ? 32'(mq[0].e) : 32'd0);
  endtask

  // Model one clock edge from the currently driven inputs, then check all outputs.
  task automatic step();
    bit   acc;
    bit   pop;
    rec_t r;
    acc = vin && (mq.size() < DEPTH);
    pop = rden && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    if (!m_active) begin
      if (acc) begin
        r.d = in0; r.lat = 0; r.e = 1'b0;
        mq.push_back(r);
        m_spur = 1'b1;
      end
      if (start) begin
        m_active = 1'b1; m_st = cyc; m_exp = expv; m_chk = chk_en;
      end
    end else if (acc) begin
      r.d = in0; r.lat = cyc - m_st; r.e = m_chk && (in0 != m_exp);
      mq.push_back(r);
      if (r.e && m_errs < 255) m_errs++;
      if (start) begin
        m_st = cyc; m_exp = expv; m_chk = chk_en;
      end else begin
        m_active = 1'b0;
      end
    end else if (cyc - m_st == TIMEOUT) begin
      m_tmo = 1'b1;
      m_active = 1'b0;
    end
    hold = vin && !acc;
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    mq.delete();
    m_active = 1'b0; m_errs = 0; m_tmo = 1'b0; m_spur = 1'b0; hold = 1'b0;
    check_all();
  endtask

  task automatic idle_inputs();
    start = 1'b0; vin = 1'b0; rden = 1'b0; chk_en = 1'b0;
  endtask

  initial begin
    // 1: single job, result three cycles after start
    idle_inputs();
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    start = 1; expv = 16'd52; chk_en = 1; step();
    start = 0; step(); step();
    vin = 1; in0 = 16'd52; step();
    vin = 0;
    chk("t1_data", 32'(rd_data), 32'd52);
    chk("t1_lat", 32'(rd_lat), 32'd3);
    chk("t1_err", 32'(rd_err), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    rden = 1; step(); rden = 0;

    // 2: mismatch, then pop to empty
    start = 1; expv = 16'd111; chk_en = 1; step();
    start = 0; vin = 1; in0 = 16'd110; step(); vin = 0;
    chk("t2_err", 32'(rd_err), 32'd1);
    chk("t2_errcnt", 32'(err_count), 32'd1);
    rden = 1; step(); rden = 0;
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_data0", 32'(rd_data), 32'd0);

    // 3: fill, stall a fifth result, release with one pop
    for (int i = 0; i < DEPTH; i++) begin
      start = 1; expv = 16'(i); chk_en = 1; step();
      start = 0; vin = 1; in0 = 16'(i); step(); vin = 0;
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ready", 32'(in_ready), 32'd0);
    start = 1; expv = 16'd99; chk_en = 1; step();
    start = 0; vin = 1; in0 = 16'd99;
    repeat (6) step();
    rden = 1; step(); rden = 0;
    step(); vin = 0;
    chk("t3_full2", 32'(full), 32'd1);
    rden = 1;
    for (int i = 1; i < DEPTH; i++) begin
      chk("t3_order", 32'(rd_data), 32'(i));
      step();
    end
    chk("t3_stall_data", 32'(rd_data), 32'd99);
    chk("t3_stall_lat", 32'(rd_lat), 32'd8);
    step(); rden = 0;

    // 4: timeout, then a normal job
    start = 1; expv = 16'd7; chk_en = 1; step();
    start = 0;
    repeat (TIMEOUT) step();
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);
    start = 1; step();
    start = 0; vin = 1; in0 = 16'd7; step(); vin = 0;
    chk("t4_lat", 32'(rd_lat), 32'd1);
    rden = 1; step(); rden = 0;

    // 5: spurious result, then back-to-back jobs
    vin = 1; in0 = 16'h55; step(); vin = 0;
    chk("t5_spur", 32'(spurious), 32'd1);
    chk("t5_lat0", 32'(rd_lat), 32'd0);
    start = 1; expv = 16'd1; chk_en = 1; step();
    start = 1; expv = 16'd2; vin = 1; in0 = 16'd1; step();
    start = 0; vin = 0; step();
    vin = 1; in0 = 16'd2; step(); vin = 0;
    rden = 1; repeat (3) step(); rden = 0;

    // 6: reset mid-run with records queued
    for (int i = 0; i < 2; i++) begin
      start = 1; expv = 16'd3; chk_en = 1; step();
      start = 0; vin = 1; in0 = 16'd4; step(); vin = 0;
    end
    start = 1; step(); start = 0; step();
    do_reset();
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_errcnt", 32'(err_count), 32'd0);

    // err_count saturation with continuous back-to-back mismatching jobs
    start = 1; expv = 16'd0; chk_en = 1; step();
    vin = 1; in0 = 16'd1; rden = 1;
    repeat (260) step();
    idle_inputs();
    chk("sat_errcnt", 32'(err_count), 32'd255);
    step(); step();
    do_reset();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      start  = ($urandom_range(0, 3) == 0);
      expv   = 16'($urandom_range(0, 3));
      chk_en = 1'($urandom_range(0, 1));
      rden   = ($urandom_range(0, 2) != 0);
      if (!hold) begin
        vin = ($urandom_range(0, 2) == 0);
        in0 = 16'($urandom_range(0, 3));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
